// File: rtl/alu_pkg.sv
// Shared definitions for the ALU: function codes, arithmetic FSM states and the
// decoder group code that routes operations to the arithmetic stage.
package alu_pkg;

  // ALU_FUN encodings within the arithmetic group
  localparam logic [1:0] ARITH_ADD = 2'b00;
  localparam logic [1:0] ARITH_SUB = 2'b01;
  localparam logic [1:0] ARITH_MUL = 2'b10;
  localparam logic [1:0] ARITH_DIV = 2'b11;

  // Decoder group code selecting the arithmetic unit
  localparam logic [1:0] ARITH_GROUP = 2'b00;

  // Two-bit state register so that unused encodings exist and can be
  // steered back to IDLE instead of locking the unit up.
  typedef logic [1:0] arith_state_t;
  localparam arith_state_t ST_IDLE = 2'b00;
  localparam arith_state_t ST_DIV  = 2'b01;

endpackage

// File: rtl/arith_unit_seq_serial_divider.sv
// Restoring divider producing one quotient bit per clock, MSB first.
// The last-step results are presented combinationally alongside o_done so the
// parent can register them on the same edge that finishes the division.
module serial_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             r_busy;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;

  logic [WIDTH:0]   w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_remNext;
  logic [WIDTH-1:0] w_quoNext;
  logic             w_last;

  // One restoring step: bring down the next dividend bit, subtract if it fits.
  // When the trial value is >= divisor the true difference is < divisor, so the
  // low WIDTH bits of a modulo subtraction are exact.
  always_comb begin
    w_trial   = {r_rem, r_quo[WIDTH-1]};
    w_ge      = (w_trial >= {1'b0, r_div});
    w_remNext = w_ge ? (w_trial[WIDTH-1:0] - r_div) : w_trial[WIDTH-1:0];
    w_quoNext = {r_quo[WIDTH-2:0], w_ge};
    w_last    = (r_cnt == CW'(WIDTH - 1));
  end

  assign o_done      = r_busy && w_last;
  assign o_quotient  = w_quoNext;
  assign o_remainder = w_remNext;

  // Load operands on start, then shift one step per edge until WIDTH steps are done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= i_dividend;
      r_div  <= i_divisor;
    end else if (r_busy) begin
      r_rem  <= w_remNext;
      r_quo  <= w_quoNext;
      r_cnt  <= r_cnt + CW'(1);
      if (w_last) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/arith_unit_seq.sv
// Arithmetic execution stage: single-cycle add/sub/mul and an iterative divide.
// Results are registered and announced with a one-cycle Arith_Flag pulse.
module arith_unit_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [1:0]         ALU_FUN,
  input  logic               Arith_EN,
  output logic [2*WIDTH-1:0] Arith_OUT,
  output logic               Carry_OUT,
  output logic               Div_Err,
  output logic               Arith_Flag,
  output logic               Busy
);

  arith_state_t       r_state;
  logic [2*WIDTH-1:0] r_out;
  logic               r_carry;
  logic               r_err;
  logic               r_flag;

  logic               w_issue;
  logic               w_divStart;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_divDone;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign Busy       = (r_state == ST_DIV);
  assign Arith_OUT  = r_out;
  assign Carry_OUT  = r_carry;
  assign Div_Err    = r_err;
  assign Arith_Flag = r_flag;

  // Issue decode and the single-cycle datapath, computed from the live operands.
  always_comb begin
    w_issue    = Arith_EN && (r_state == ST_IDLE);
    w_divStart = w_issue && (ALU_FUN == ARITH_DIV) && (B != '0);
    w_sum      = {1'b0, A} + {1'b0, B};
    w_diff     = A - B;
    w_prod     = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
  end

  serial_divider #(.WIDTH(WIDTH)) u_divider (
    .clk         (CLK),
    .rst_n       (RST),
    .i_start     (w_divStart),
    .i_dividend  (A),
    .i_divisor   (B),
    .o_done      (w_divDone),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  // FSM and output registers; outputs only change on a completing edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
      r_out   <= '0;
      r_carry <= 1'b0;
      r_err   <= 1'b0;
      r_flag  <= 1'b0;
    end else begin
      r_flag <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            case (ALU_FUN)
              ARITH_ADD: begin
                r_out   <= {{WIDTH{1'b0}}, w_sum[WIDTH-1:0]};
                r_carry <= w_sum[WIDTH];
                r_err   <= 1'b0;
                r_flag  <= 1'b1;
              end
              ARITH_SUB: begin
                r_out   <= {{WIDTH{1'b0}}, w_diff};
                r_carry <= (A < B);
                r_err   <= 1'b0;
                r_flag  <= 1'b1;
              end
              ARITH_MUL: begin
                r_out   <= w_prod;
                r_carry <= 1'b0;
                r_err   <= 1'b0;
                r_flag  <= 1'b1;
              end
              default: begin
                if (B == '0) begin
                  r_out   <= {A, {WIDTH{1'b1}}};
                  r_carry <= 1'b0;
                  r_err   <= 1'b1;
                  r_flag  <= 1'b1;
                end else begin
                  r_state <= ST_DIV;
                end
              end
            endcase
          end
        end
        ST_DIV: begin
          if (w_divDone) begin
            r_out   <= {w_rem, w_quo};
            r_carry <= 1'b0;
            r_err   <= 1'b0;
            r_flag  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arith_unit_seq.sv
// Self-checking bench for arith_unit_seq (WIDTH=16): directed cases, a reset
// during a divide, randomized single ops and a back-to-back add/sub/mul stream.
module tb_arith_unit_seq;
  import alu_pkg::*;

  localparam int W = 16;

  logic           CLK;
  logic           RST;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic [1:0]     ALU_FUN;
  logic           Arith_EN;
  logic [2*W-1:0] Arith_OUT;
  logic           Carry_OUT;
  logic           Div_Err;
  logic           Arith_Flag;
  logic           Busy;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] lastOut = '0;

  arith_unit_seq #(.WIDTH(W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .A          (A),
    .B          (B),
    .ALU_FUN    (ALU_FUN),
    .Arith_EN   (Arith_EN),
    .Arith_OUT  (Arith_OUT),
    .Carry_OUT  (Carry_OUT),
    .Div_Err    (Div_Err),
    .Arith_Flag (Arith_Flag),
    .Busy       (Busy)
  );

  // Free-running clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Reference model straight from the arithmetic definitions
  function automatic void refModel(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] fun,
                                   output logic [2*W-1:0] out, output logic carry, output logic err,
                                   output int lat, output int busyCycles);
    longint unsigned la = longint'(a);
    longint unsigned lb = longint'(b);
    longint unsigned v;
    carry = 1'b0; err = 1'b0; lat = 1; busyCycles = 0; v = 0;
    case (fun)
      ARITH_ADD: begin v = (la + lb) % 65536; carry = ((la + lb) >= 65536); end
      ARITH_SUB: begin v = (la + 65536 - lb) % 65536; carry = (la < lb); end
      ARITH_MUL: v = la * lb;
      default: begin
        if (lb == 0) begin v = la * 65536 + 65535; err = 1'b1; end
        else begin v = (la % lb) * 65536 + (la / lb); lat = W + 1; busyCycles = W; end
      end
    endcase
    out = 32'(v);
  endfunction

  // Issue one op, wait (bounded) for its flag, and check result, latency and busy time.
  // Optionally injects an add issue in the middle of a divide, which must be ignored.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] fun, input bit pulseMid);
    logic [2*W-1:0] expOut;
    logic expCarry, expErr;
    int expLat, expBusy, edges, busyCnt;
    bit sawFlag, heldOk;
    refModel(a, b, fun, expOut, expCarry, expErr, expLat, expBusy);
    @(negedge CLK);
    A = a; B = b; ALU_FUN = fun; Arith_EN = 1'b1;
    edges = 0; busyCnt = 0; sawFlag = 0; heldOk = 1;
    while (!sawFlag && edges < 40) begin
      @(posedge CLK); #1;
      edges++;
      Arith_EN = 1'b0;
      if (Arith_Flag) sawFlag = 1;
      else begin
        if (Busy) busyCnt++;
        if (Arith_OUT !== lastOut) heldOk = 0;
        if (pulseMid && edges == 5) begin
          A = W'($urandom); B = W'($urandom); ALU_FUN = ARITH_ADD; Arith_EN = 1'b1;
        end
      end
    end
    checkOutput("flagSeen", 64'(sawFlag), 64'd1);
    checkOutput("latency", 64'(edges), 64'(expLat));
    checkOutput("result", 64'(Arith_OUT), 64'(expOut));
    checkOutput("carry", 64'(Carry_OUT), 64'(expCarry));
    checkOutput("divErr", 64'(Div_Err), 64'(expErr));
    checkOutput("busyCycles", 64'(busyCnt), 64'(expBusy));
    checkOutput("holdWhileBusy", 64'(heldOk), 64'd1);
    checkOutput("busyAfter", 64'(Busy), 64'd0);
    lastOut = expOut;
    @(posedge CLK); #1;
    checkOutput("flagOneCycle", 64'(Arith_Flag), 64'd0);
    checkOutput("resultHeld", 64'(Arith_OUT), 64'(expOut));
  endtask

  // Continuous issue of add/sub/mul, one per cycle, each checked on the following edge
  task automatic streamOps(input int n);
    logic [2*W-1:0] expOut;
    logic expCarry, expErr;
    int expLat, expBusy;
    logic [W-1:0] a, b;
    logic [1:0] fun;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      a = W'($urandom); b = W'($urandom); fun = 2'($urandom_range(0, 2));
      A = a; B = b; ALU_FUN = fun; Arith_EN = 1'b1;
      refModel(a, b, fun, expOut, expCarry, expErr, expLat, expBusy);
      @(posedge CLK); #1;
      checkOutput("streamFlag", 64'(Arith_Flag), 64'd1);
      checkOutput("streamResult", 64'(Arith_OUT), 64'(expOut));
      checkOutput("streamCarry", 64'(Carry_OUT), 64'(expCarry));
      checkOutput("streamErr", 64'(Div_Err), 64'(expErr));
      lastOut = expOut;
    end
    @(negedge CLK);
    Arith_EN = 1'b0;
  endtask

  initial begin
    int flagCount;
    RST = 1'b0; Arith_EN = 1'b0; A = '0; B = '0; ALU_FUN = ARITH_ADD;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("rstOut", 64'(Arith_OUT), 64'd0);
    checkOutput("rstCarry", 64'(Carry_OUT), 64'd0);
    checkOutput("rstErr", 64'(Div_Err), 64'd0);
    checkOutput("rstFlag", 64'(Arith_Flag), 64'd0);
    checkOutput("rstBusy", 64'(Busy), 64'd0);
    @(negedge CLK);
    RST = 1'b1;

    // Directed cases
    applyStimulus(16'h1234, 16'h0001, ARITH_ADD, 1'b0);
    applyStimulus(16'hFFFF, 16'h0002, ARITH_ADD, 1'b0);
    applyStimulus(16'd3, 16'd5, ARITH_SUB, 1'b0);
    applyStimulus(16'hFFFF, 16'hFFFF, ARITH_MUL, 1'b0);
    applyStimulus(16'd100, 16'd7, ARITH_DIV, 1'b1);
    applyStimulus(16'h00AB, 16'h0000, ARITH_DIV, 1'b0);

    // Reset during a divide: everything clears immediately, nothing published later
    @(negedge CLK);
    A = 16'd1000; B = 16'd3; ALU_FUN = ARITH_DIV; Arith_EN = 1'b1;
    @(posedge CLK); #1;
    Arith_EN = 1'b0;
    repeat (4) @(posedge CLK);
    #2;
    RST = 1'b0;
    #1;
    checkOutput("midRstOut", 64'(Arith_OUT), 64'd0);
    checkOutput("midRstErr", 64'(Div_Err), 64'd0);
    checkOutput("midRstBusy", 64'(Busy), 64'd0);
    checkOutput("midRstFlag", 64'(Arith_Flag), 64'd0);
    @(negedge CLK);
    RST = 1'b1;
    lastOut = '0;
    flagCount = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge CLK); #1;
      if (Arith_Flag) flagCount++;
    end
    checkOutput("noFlagAfterRst", 64'(flagCount), 64'd0);
    checkOutput("outAfterRst", 64'(Arith_OUT), 64'd0);

    // Randomized single operations, including divide-by-zero
    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      applyStimulus(ra, rb, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Back-to-back throughput
    streamOps(40);
    applyStimulus(16'd65535, 16'd1, ARITH_DIV, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
